// File: rtl/reg_file_sb_pkg.sv
// Shared sizing constants and helpers for the register file with scoreboard.
package reg_file_sb_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADR_W  = 3;
    localparam int CNT_W  = $clog2(NREGS + 1);

    // True when exactly one bit of the location vector is set.
    function automatic logic onehot_legal(input logic [NREGS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return (cnt == CNT_W'(1));
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between decoder/issue/operand-fetch logic and the register file.
interface reg_file_sb_if;
    import reg_file_sb_pkg::*;

    logic              wr_valid;
    logic [NREGS-1:0]  wr_loc;
    logic [DATA_W-1:0] wr_data;
    logic              iss_valid;
    logic [NREGS-1:0]  iss_loc;
    logic [ADR_W-1:0]  rd_adr_a;
    logic [ADR_W-1:0]  rd_adr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic [NREGS-1:0]  pend;
    logic              err_onehot;

    // Register-file side.
    modport slave (
        input  wr_valid, wr_loc, wr_data, iss_valid, iss_loc, rd_adr_a, rd_adr_b,
        output rd_data_a, rd_data_b, busy_a, busy_b, pend, err_onehot
    );

    // Pipeline side driving writeback, issue and read addresses.
    modport master (
        output wr_valid, wr_loc, wr_data, iss_valid, iss_loc, rd_adr_a, rd_adr_b,
        input  rd_data_a, rd_data_b, busy_a, busy_b, pend, err_onehot
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by writeback.
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NREGS-1:0] set_vec,   // legal, R0-masked issue marks
    input  logic [NREGS-1:0] clr_vec,   // legal, R0-masked writeback marks
    input  logic [ADR_W-1:0] adr_a,
    input  logic [ADR_W-1:0] adr_b,
    output logic [NREGS-1:0] pend,
    output logic             busy_a,
    output logic             busy_b
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Next pending state: a new producer (set) beats a completing one (clr).
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < NREGS; i++) begin
            if (set_vec[i]) begin
                pend_d[i] = 1'b1;
            end else if (clr_vec[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard state, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

    // A writeback landing this cycle is bypassed, so it no longer counts as a hazard.
    assign busy_a = pend_q[adr_a] & ~clr_vec[adr_a];
    assign busy_b = pend_q[adr_b] & ~clr_vec[adr_b];

endmodule

// File: rtl/reg_file_sb.sv
// 8-entry register file with write-through bypass and pending-write scoreboard.
// R0 reads as zero and ignores writes and issue marks.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    logic              wr_legal;
    logic              iss_legal;
    logic [NREGS-1:0]  wr_en;
    logic [NREGS-1:0]  iss_en;
    logic              err_q;
    logic              err_d;
    logic [DATA_W-1:0] reg_q [NREGS];
    logic [DATA_W-1:0] reg_d [NREGS];
    logic [ADR_W-1:0]  rd_adr  [2];
    logic [DATA_W-1:0] rd_data [2];

    assign wr_legal  = onehot_legal(bus.wr_loc);
    assign iss_legal = onehot_legal(bus.iss_loc);

    // Qualified one-hot enables; illegal vectors and R0 produce no action.
    always_comb begin
        wr_en  = '0;
        iss_en = '0;
        if (bus.wr_valid && wr_legal) begin
            wr_en = {bus.wr_loc[NREGS-1:1], 1'b0};
        end
        if (bus.iss_valid && iss_legal) begin
            iss_en = {bus.iss_loc[NREGS-1:1], 1'b0};
        end
    end

    // Next register contents and sticky one-hot error flag.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            reg_d[i] = reg_q[i];
            if (wr_en[i]) begin
                reg_d[i] = bus.wr_data;
            end
        end
        reg_d[0] = '0;
        err_d = err_q
              | (bus.wr_valid  & ~wr_legal)
              | (bus.iss_valid & ~iss_legal);
    end

    // Storage and error flag; reset clears everything and drops a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            err_q <= err_d;
        end
    end

    assign rd_adr[0] = bus.rd_adr_a;
    assign rd_adr[1] = bus.rd_adr_b;

    // Read ports: wr_en[0] is never set, so address 0 always falls through to reg_q[0] = 0.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rd_data[gi] = wr_en[rd_adr[gi]] ? bus.wr_data : reg_q[rd_adr[gi]];
    end

    assign bus.rd_data_a  = rd_data[0];
    assign bus.rd_data_b  = rd_data[1];
    assign bus.err_onehot = err_q;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_vec (iss_en),
        .clr_vec (wr_en),
        .adr_a   (bus.rd_adr_a),
        .adr_b   (bus.rd_adr_b),
        .pend    (bus.pend),
        .busy_a  (bus.busy_a),
        .busy_b  (bus.busy_b)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one task per feature, inline checks.
module tb_reg_file_sb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_file_sb_if bus ();

    reg_file_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.wr_valid  = 1'b0;
        bus.wr_loc    = 8'h00;
        bus.wr_data   = 16'h0000;
        bus.iss_valid = 1'b0;
        bus.iss_loc   = 8'h00;
    endtask

    task automatic do_write(input logic [7:0] loc, input logic [15:0] data);
        @(negedge clk);
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_loc   = loc;
        bus.wr_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Build up some state first, then pulse reset between edges.
        do_write(8'h10, 16'hA5A5);
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h40;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h03;
        @(posedge clk);
        @(negedge clk);
        idle();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.pend !== 8'h00) begin
            bad++;
            $display("FAIL reset_pend: got %h expected 00", bus.pend);
        end
        total++;
        if (bus.err_onehot !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b expected 0", bus.err_onehot);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_adr_a = 3'(i);
            bus.rd_adr_b = 3'(7 - i);
            #1;
            total++;
            if (bus.rd_data_a !== 16'h0000 || bus.rd_data_b !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read adr %0d: got a=%h b=%h expected 0000", i, bus.rd_data_a, bus.rd_data_b);
            end
            total++;
            if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy adr %0d: got a=%b b=%b expected 0", i, bus.busy_a, bus.busy_b);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        idle();
        bus.rd_adr_a = 3'd3;
        bus.rd_adr_b = 3'd3;
        #1;
        total++;
        if (bus.rd_data_b !== 16'h0000) begin
            bad++;
            $display("FAIL pre_write_b: got %h expected 0000", bus.rd_data_b);
        end
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h08;
        bus.wr_data  = 16'hBEEF;
        #1;
        total++;
        if (bus.rd_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL bypass_a: got %h expected beef", bus.rd_data_a);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bus.rd_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL stored_a: got %h expected beef", bus.rd_data_a);
        end
        $display("test_write_bypass: wrote r3=beef");
    endtask

    task automatic test_r0();
        @(negedge clk);
        idle();
        bus.rd_adr_a = 3'd0;
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h01;
        bus.wr_data  = 16'h1234;
        #1;
        total++;
        if (bus.rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL r0_bypass: got %h expected 0000", bus.rd_data_a);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h01;
        #1;
        total++;
        if (bus.rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL r0_stored: got %h expected 0000", bus.rd_data_a);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'h00) begin
            bad++;
            $display("FAIL r0_pend: got %h expected 00", bus.pend);
        end
        total++;
        if (bus.err_onehot !== 1'b0) begin
            bad++;
            $display("FAIL r0_err: got %b expected 0", bus.err_onehot);
        end
        $display("test_r0: done");
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h20;
        @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'h20) begin
            bad++;
            $display("FAIL sb_issue_pend: got %h expected 20", bus.pend);
        end
        @(negedge clk);
        idle();
        bus.rd_adr_a = 3'd5;
        bus.rd_adr_b = 3'd4;
        #1;
        total++;
        if (bus.busy_a !== 1'b1 || bus.busy_b !== 1'b0) begin
            bad++;
            $display("FAIL sb_busy: got a=%b b=%b expected a=1 b=0", bus.busy_a, bus.busy_b);
        end
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h20;
        bus.wr_data  = 16'h5555;
        #1;
        total++;
        if (bus.busy_a !== 1'b0 || bus.rd_data_a !== 16'h5555) begin
            bad++;
            $display("FAIL sb_wb_same_cycle: got busy=%b data=%h expected busy=0 data=5555", bus.busy_a, bus.rd_data_a);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'h00) begin
            bad++;
            $display("FAIL sb_clear: got %h expected 00", bus.pend);
        end
        // Simultaneous issue and writeback: new producer keeps the bit set.
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h20;
        bus.wr_valid  = 1'b1;
        bus.wr_loc    = 8'h20;
        bus.wr_data   = 16'h6666;
        @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'h20) begin
            bad++;
            $display("FAIL sb_set_wins: got %h expected 20", bus.pend);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bus.rd_data_a !== 16'h6666 || bus.busy_a !== 1'b1) begin
            bad++;
            $display("FAIL sb_set_wins_read: got data=%h busy=%b expected 6666 busy=1", bus.rd_data_a, bus.busy_a);
        end
        // Re-issue to a pending register, plus a second register.
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h20;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h80;
        @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'hA0) begin
            bad++;
            $display("FAIL sb_reissue: got %h expected a0", bus.pend);
        end
        do_write(8'h20, 16'h7777);
        do_write(8'h80, 16'h8888);
        // Clearing an already-clear bit stays silent.
        do_write(8'h80, 16'h9999);
        total++;
        if (bus.pend !== 8'h00 || bus.err_onehot !== 1'b0) begin
            bad++;
            $display("FAIL sb_drain: got pend=%h err=%b expected 00 0", bus.pend, bus.err_onehot);
        end
        $display("test_scoreboard: done");
    endtask

    task automatic test_dual_ports();
        for (int i = 0; i < 8; i++) begin
            do_write(8'(1 << i), 16'(i * 16'h1111));
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_a;
            logic [15:0] exp_b;
            exp_a = (i == 0) ? 16'h0000 : 16'(i * 16'h1111);
            exp_b = (i == 7) ? 16'h0000 : 16'((7 - i) * 16'h1111);
            bus.rd_adr_a = 3'(i);
            bus.rd_adr_b = 3'(7 - i);
            #1;
            total++;
            if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                bad++;
                $display("FAIL dual_read %0d: got a=%h b=%h expected a=%h b=%h", i, bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
            end
            $display("dual_read a=%0d b=%0d: a=%h b=%h", i, 7 - i, bus.rd_data_a, bus.rd_data_b);
        end
    endtask

    task automatic test_illegal();
        do_write(8'h04, 16'h2222);
        do_write(8'h08, 16'h3333);
        @(negedge clk);
        idle();
        bus.rd_adr_a = 3'd2;
        bus.rd_adr_b = 3'd3;
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h0C;
        bus.wr_data  = 16'hFFFF;
        #1;
        total++;
        if (bus.rd_data_a !== 16'h2222 || bus.rd_data_b !== 16'h3333 || bus.err_onehot !== 1'b0) begin
            bad++;
            $display("FAIL illegal_no_bypass: got a=%h b=%h err=%b expected 2222 3333 0", bus.rd_data_a, bus.rd_data_b, bus.err_onehot);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.err_onehot !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err_set: got %b expected 1", bus.err_onehot);
        end
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_loc   = 8'h06;
        #1;
        total++;
        if (bus.rd_data_a !== 16'h2222 || bus.rd_data_b !== 16'h3333) begin
            bad++;
            $display("FAIL illegal_no_write: got a=%h b=%h expected 2222 3333", bus.rd_data_a, bus.rd_data_b);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h00;
        @(posedge clk);
        @(negedge clk);
        idle();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.pend !== 8'h00 || bus.err_onehot !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sticky: got pend=%h err=%b expected 00 1", bus.pend, bus.err_onehot);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.err_onehot !== 1'b0 || bus.rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL illegal_rst_clear: got err=%b a=%h expected 0 0000", bus.err_onehot, bus.rd_data_a);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_illegal: done");
    endtask

    task automatic test_write_during_reset();
        // A write presented on the edge where reset is held is lost.
        @(negedge clk);
        idle();
        rst          = 1'b1;
        bus.rd_adr_a = 3'd6;
        bus.wr_valid = 1'b1;
        bus.wr_loc   = 8'h40;
        bus.wr_data  = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        total++;
        if (bus.rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL write_in_reset: got %h expected 0000", bus.rd_data_a);
        end
        $display("test_write_during_reset: done");
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.rd_adr_a = 3'd0;
        bus.rd_adr_b = 3'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_bypass();
        test_r0();
        test_scoreboard();
        test_dual_ports();
        test_illegal();
        test_write_during_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
